// File: rtl/ins_ram_arbiter_if.sv
// Bus bundle for ins_ram_arbiter: CPU fetch port, host loader port and the
// single-port instruction RAM port. The arbiter takes the slave view; the
// requesters and RAM model on the other side take the master view.
interface ins_ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // CPU fetch port
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_ins;
    logic          cpu_ack;

    // Host loader port
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          host_err;

    // RAM macro port
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_rdata,
        output cpu_ins, cpu_ack,
        output host_rdata, host_ack, host_err,
        output ram_cs, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_addr,
        output host_req, host_we, host_addr, host_wdata,
        output ram_rdata,
        input  cpu_ins, cpu_ack,
        input  host_rdata, host_ack, host_err,
        input  ram_cs, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ins_ram_arbiter.sv
// ins_ram_arbiter: serializes CPU fetches and host loader accesses onto one
// single-port instruction RAM. Each transaction takes IDLE -> ACCESS -> DONE;
// the host wins collisions until the CPU has been passed over STARVE_LIM times.
// Optional feature: define INS_ARB_WPROT_EN to reject host writes below
// WPROT_LIMIT (access still runs with ram_we low; host_err flags it).
module ins_ram_arbiter #(
    parameter int            AW          = 16,
    parameter int            DW          = 16,
    parameter int            STARVE_LIM  = 4,
    parameter logic [AW-1:0] WPROT_LIMIT = AW'(16'h0020)
) (
    input  logic             clk,
    input  logic             rst,
    ins_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);
    localparam logic [2:0] STARVE_SAT = 3'd7;

    state_t        state;
    logic          grant_cpu;      // 1: CPU owns the current transaction
    logic          host_rd;        // current host transaction is a read
    logic          wprot_err;      // current host write was rejected
    logic [2:0]    starve_cnt;
    logic [DW-1:0] cpu_ins_reg;
    logic [DW-1:0] host_rdata_reg;
    logic          cpu_ack_reg;
    logic          host_ack_reg;
    logic          host_err_reg;
    logic          ram_cs_reg;
    logic          ram_we_reg;
    logic [AW-1:0] ram_addr_reg;
    logic [DW-1:0] ram_wdata_reg;

    logic          cpu_first;
    logic          wprot_hit;

    // CPU is granted when alone, or when it has waited out its starvation budget.
    assign cpu_first = bus.cpu_req && (!bus.host_req || (starve_cnt == STARVE_MAX));

`ifdef INS_ARB_WPROT_EN
    assign wprot_hit = bus.host_we && (bus.host_addr < WPROT_LIMIT);
`else
    assign wprot_hit = 1'b0;
    logic unused_wprot;
    assign unused_wprot = ^WPROT_LIMIT;
`endif

    // Single FSM: grant in IDLE, drive the RAM in ACCESS, acknowledge in DONE.
    // Async reset also kills ram_we mid-access, so no write survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            grant_cpu      <= 1'b0;
            host_rd        <= 1'b0;
            wprot_err      <= 1'b0;
            starve_cnt     <= '0;
            cpu_ins_reg    <= '0;
            host_rdata_reg <= '0;
            cpu_ack_reg    <= 1'b0;
            host_ack_reg   <= 1'b0;
            host_err_reg   <= 1'b0;
            ram_cs_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_first) begin
                        grant_cpu     <= 1'b1;
                        host_rd       <= 1'b0;
                        wprot_err     <= 1'b0;
                        ram_addr_reg  <= bus.cpu_addr;
                        ram_wdata_reg <= '0;
                        ram_we_reg    <= 1'b0;
                        ram_cs_reg    <= 1'b1;
                        starve_cnt    <= '0;
                        state         <= ACCESS;
                    end else if (bus.host_req) begin
                        grant_cpu     <= 1'b0;
                        host_rd       <= !bus.host_we;
                        wprot_err     <= wprot_hit;
                        ram_addr_reg  <= bus.host_addr;
                        ram_wdata_reg <= bus.host_wdata;
                        ram_we_reg    <= bus.host_we && !wprot_hit;
                        ram_cs_reg    <= 1'b1;
                        if (!bus.cpu_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_SAT) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                        state         <= ACCESS;
                    end else begin
                        // nobody asking, which implies cpu_req is low
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    ram_cs_reg   <= 1'b0;
                    ram_we_reg   <= 1'b0;
                    cpu_ack_reg  <= grant_cpu;
                    host_ack_reg <= !grant_cpu;
                    host_err_reg <= !grant_cpu && wprot_err;
                    state        <= DONE;
                end
                DONE: begin
                    if (grant_cpu) begin
                        cpu_ins_reg <= bus.ram_rdata;
                    end else if (host_rd) begin
                        host_rdata_reg <= bus.ram_rdata;
                    end
                    cpu_ack_reg  <= 1'b0;
                    host_ack_reg <= 1'b0;
                    host_err_reg <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM data only arrives in DONE, so read data is forwarded straight through
    // while the ack is high and held from the capture register afterwards.
    assign bus.cpu_ins    = cpu_ack_reg ? bus.ram_rdata : cpu_ins_reg;
    assign bus.host_rdata = (host_ack_reg && host_rd) ? bus.ram_rdata : host_rdata_reg;
    assign bus.cpu_ack    = cpu_ack_reg;
    assign bus.host_ack   = host_ack_reg;
    assign bus.host_err   = host_err_reg;
    assign bus.ram_cs     = ram_cs_reg;
    assign bus.ram_we     = ram_we_reg;
    assign bus.ram_addr   = ram_addr_reg;
    assign bus.ram_wdata  = ram_wdata_reg;

endmodule

// File: tb/tb_ins_ram_arbiter.sv
// Testbench for ins_ram_arbiter: randomized rounds of CPU/host traffic, a
// reference model that predicts grant order and data, and a scoreboard
// monitor that checks every RAM access and every acknowledge.
module tb_ins_ram_arbiter;

    localparam int          AW          = 16;
    localparam int          DW          = 16;
    localparam int          STARVE_LIM  = 4;
    localparam logic [15:0] WPROT_LIMIT = 16'h0020;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ins_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ins_ram_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIM(STARVE_LIM), .WPROT_LIMIT(WPROT_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction RAM macro: registered read, data valid the cycle after ram_cs.
    logic [15:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            bus.ram_rdata <= ram_mem[bus.ram_addr[7:0]];
        end
    end

    typedef struct {
        bit          is_cpu;
        bit          rd;
        bit          ram_we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] last_cpu = '0;
    logic [15:0] last_host = '0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    bit          h_we   [8];
    logic [15:0] h_addr [8];
    logic [15:0] h_data [8];
    logic [15:0] c_addr [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Scoreboard monitor: checks the head transaction on its RAM access and ack.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t h;
            check("single_ack", 32'(bus.cpu_ack & bus.host_ack), 0);
            if (bus.ram_cs) begin
                if (sbq.size() == 0) begin
                    check("ram_cs_unexpected", 32'(bus.ram_cs), 0);
                end else begin
                    h = sbq[0];
                    check("access_cycle", cyc, h.cyc - 1);
                    check("ram_addr", 32'(bus.ram_addr), 32'(h.addr));
                    check("ram_we", 32'(bus.ram_we), 32'(h.ram_we));
                    if (h.ram_we) check("ram_wdata", 32'(bus.ram_wdata), 32'(h.wdata));
                end
            end
            if (bus.cpu_ack || bus.host_ack) begin
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 32'({bus.cpu_ack, bus.host_ack}), 0);
                end else begin
                    h = sbq.pop_front();
                    $display("cyc %0d: %s %s addr=%h data=%h err=%0d", cyc,
                             h.is_cpu ? "cpu " : "host", h.rd ? "rd" : "wr", h.addr,
                             h.rd ? h.rdata : h.wdata, h.err);
                    check("ack_owner", 32'(bus.cpu_ack), 32'(h.is_cpu));
                    check("ack_cycle", cyc, h.cyc);
                    if (h.is_cpu) begin
                        check("cpu_ins", 32'(bus.cpu_ins), 32'(h.rdata));
                        last_cpu = h.rdata;
                        check("host_rdata_hold", 32'(bus.host_rdata), 32'(last_host));
                    end else begin
                        check("host_err", 32'(bus.host_err), 32'(h.err));
                        if (h.rd) begin
                            check("host_rdata", 32'(bus.host_rdata), 32'(h.rdata));
                            last_host = h.rdata;
                        end else begin
                            check("host_rdata_hold", 32'(bus.host_rdata), 32'(last_host));
                        end
                        check("cpu_ins_hold", 32'(bus.cpu_ins), 32'(last_cpu));
                    end
                end
            end else begin
                check("cpu_ins_hold", 32'(bus.cpu_ins), 32'(last_cpu));
                check("host_rdata_hold", 32'(bus.host_rdata), 32'(last_host));
                check("host_err_idle", 32'(bus.host_err), 0);
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            h_we[i]   = 1'($urandom_range(0, 1));
            h_addr[i] = 16'($urandom_range(0, 63));
            h_data[i] = 16'($urandom);
        end
        for (int i = 0; i < 4; i++) c_addr[i] = 16'($urandom_range(0, 63));
    endtask

    task automatic set_host(input int i);
        bus.host_we    = h_we[i];
        bus.host_addr  = h_addr[i];
        bus.host_wdata = h_data[i];
    endtask

    // One round: host issues nh back-to-back transactions, CPU issues nc, both
    // starting in the same IDLE cycle. Expected order comes from the rule
    // "host first unless the CPU has already been passed over STARVE_LIM times".
    task automatic run_round(input int nh, input int nc);
        int   seq[$];
        int   passed = 0, hl = nh, cl = nc, hp = 0, cp = 0, w = 0;
        int   start, hdone = 0, cdone = 0, idx;
        bit   prot;
        exp_t e;
        start = cyc;
        while (hl > 0 || cl > 0) begin
            e = '{default: 0};
            if (cl > 0 && (hl == 0 || passed == STARVE_LIM)) begin
                e.is_cpu = 1; e.rd = 1; e.addr = c_addr[cp];
                e.rdata = ref_mem[c_addr[cp][7:0]];
                cp++; cl--; passed = 0;
            end else begin
                prot = 0;
`ifdef INS_ARB_WPROT_EN
                prot = h_we[hp] && (h_addr[hp] < WPROT_LIMIT);
`endif
                e.is_cpu = 0; e.rd = !h_we[hp]; e.addr = h_addr[hp]; e.wdata = h_data[hp];
                e.ram_we = h_we[hp] && !prot; e.err = prot;
                e.rdata = ref_mem[h_addr[hp][7:0]];
                if (e.ram_we) ref_mem[h_addr[hp][7:0]] = h_data[hp];
                hp++; hl--;
                passed = (cl > 0) ? passed + 1 : 0;
            end
            e.cyc = start + 2 + 3 * w;
            w++;
            seq.push_back(int'(e.is_cpu));
            sbq.push_back(e);
        end
        if (nh > 0) begin set_host(0); bus.host_req = 1'b1; end
        if (nc > 0) begin bus.cpu_addr = c_addr[0]; bus.cpu_req = 1'b1; end
        for (int k = 0; k < 3 * (nh + nc) + 6 && (hdone < nh || cdone < nc); k++) begin
            @(negedge clk);
            // scramble the in-flight requester's inputs: only the grant-time copy may matter
            if (bus.ram_cs && cyc > start) begin
                idx = (cyc - start - 1) / 3;
                if (idx < seq.size()) begin
                    if (seq[idx] != 0) bus.cpu_addr = 16'($urandom);
                    else begin
                        bus.host_addr  = 16'($urandom);
                        bus.host_wdata = 16'($urandom);
                        bus.host_we    = 1'($urandom_range(0, 1));
                    end
                end
            end
            if (bus.host_ack && hdone < nh) begin
                hdone++;
                if (hdone < nh) set_host(hdone); else bus.host_req = 1'b0;
            end
            if (bus.cpu_ack && cdone < nc) begin
                cdone++;
                if (cdone < nc) bus.cpu_addr = c_addr[cdone]; else bus.cpu_req = 1'b0;
            end
        end
        check("round_complete", hdone + cdone, nh + nc);
        if (hdone + cdone != nh + nc) sbq.delete();
        bus.host_req = 1'b0;
        bus.cpu_req  = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        int nh, nc;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.cpu_req = 0; bus.cpu_addr = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;

        // reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cpu_ins", 32'(bus.cpu_ins), 0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        check("rst_host_rdata", 32'(bus.host_rdata), 0);
        check("rst_host_ack", 32'(bus.host_ack), 0);
        check("rst_host_err", 32'(bus.host_err), 0);
        check("rst_ram_cs", 32'(bus.ram_cs), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_ram_addr", 32'(bus.ram_addr), 0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
        mem_clr = 1'b0;
        rst     = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // host write then CPU fetch of the same word
        h_we[0] = 1; h_addr[0] = 16'h0040; h_data[0] = 16'h0458;
        run_round(1, 0);
        gap();
        c_addr[0] = 16'h0040;
        run_round(0, 1);
        repeat (4) @(negedge clk);

        // collision: host first, CPU three cycles later
        h_we[0] = 0; h_addr[0] = 16'h0040; c_addr[0] = 16'h0040;
        run_round(1, 1);
        gap();

        // starvation: four host grants, CPU, then host again
        fill_random();
        run_round(6, 1);
        gap();

        // write protection boundary, then CPU reads the same word
        h_we[0] = 1; h_addr[0] = 16'h0010; h_data[0] = 16'hFFFF; c_addr[0] = 16'h0010;
        run_round(1, 1);
        gap();
        h_we[0] = 1; h_addr[0] = 16'h0020; h_data[0] = 16'h1234; c_addr[0] = 16'h0020;
        run_round(1, 1);
        gap();

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            fill_random();
            nh = $urandom_range(0, 6);
            nc = (nh == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            run_round(nh, nc);
            gap();
        end

        // reset asserted during a host write's ACCESS cycle
        mon_en = 1'b0;
        bus.host_we = 1; bus.host_addr = 16'h0030; bus.host_wdata = 16'hBEEF; bus.host_req = 1;
        @(negedge clk);
        check("midrst_access_cs", 32'(bus.ram_cs), 1);
        check("midrst_access_we", 32'(bus.ram_we), 1);
        #1 rst = 1'b0;
        bus.host_req = 1'b0;
        #1;
        check("midrst_we_async", 32'(bus.ram_we), 0);
        check("midrst_cs_async", 32'(bus.ram_cs), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_host_ack", 32'(bus.host_ack), 0);
            check("midrst_no_cpu_ack", 32'(bus.cpu_ack), 0);
        end
        rst = 1'b1;
        last_cpu  = '0;
        last_host = '0;
        check("midrst_cpu_ins", 32'(bus.cpu_ins), 0);
        check("midrst_host_rdata", 32'(bus.host_rdata), 0);
        @(negedge clk);
        mon_en = 1'b1;
        h_we[0] = 0; h_addr[0] = 16'h0030; c_addr[0] = 16'h0030;
        run_round(1, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
